fft_acc_pingpong_ram: RTL and testbench
=======================================

# fft_acc_pingpong_ram

Parametrised dual-bank (ping-pong) on-chip memory for the FFT accelerator, with two Avalon-MM slave ports on one clock. Port A (sample loader / result reader) and port B (FFT core) always address opposite banks, and a drain-then-swap handshake exchanges the banks between FFT frames. It adds a configurable read latency, readdatavalid and waitrequest signalling, and optional bit-reversed addressing on port B.

## Interface

Parameters:
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, 10: word address width; each bank holds 2^ADDR_WIDTH words.
- READ_LATENCY, 1: cycles from an accepted read to readdatavalid; legal values are 1 and 2.

Ports (x = a or b; both ports are identical):
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- x_address  in  ADDR_WIDTH  word address.
- x_chipselect  in  1  qualifies x_read and x_write.
- x_read  in  1  read request.
- x_write  in  1  write request.
- x_byteenable  in  DATA_WIDTH/8  write byte lanes.
- x_writedata  in  DATA_WIDTH  write data.
- x_readdata  out  DATA_WIDTH  read data.
- x_readdatavalid  out  1  one-cycle strobe; x_readdata is valid while it is high.
- x_waitrequest  out  1  command stall.
- b_bitrev  in  1  bit-reverse port B address; the port exists only with FFT_PP_BITREV_EN.
- swap_req  in  1  request a bank exchange.
- swap_ack  out  1  one-cycle pulse when the exchange completes.
- bank_sel  out  1  bank addressed by port A; port B addresses ~bank_sel.

## Operation

- Command acceptance: a command is accepted on a cycle with chipselect=1, (read|write)=1 and waitrequest=0.
- Write: every byte lane i with byteenable[i]=1 is updated. Lanes with byteenable[i]=0 keep their previous value.
- Read+write on the same cycle (same port): the write is performed. The read is dropped and produces no readdatavalid.
- Port independence: the two ports never address the same bank, so there are no inter-port collisions and no arbitration between A and B.
- In-flight tracking: an in-flight counter holds the number of accepted reads whose readdatavalid has not yet occurred, summed over both ports (range 0..2*READ_LATENCY).
- Swap FSM, IDLE: waitrequest=0. If swap_req=1, go to DRAIN on the next cycle; the command presented on that same cycle is still accepted.
- Swap FSM, DRAIN: both waitrequests=1. When the in-flight counter reaches 0, go to SWAP.
- Swap FSM, SWAP: both waitrequests=1. bank_sel toggles at the end of this cycle, swap_ack=1 during this cycle, then go to IDLE.
- swap_req is sampled only in IDLE. It is ignored in DRAIN and SWAP. If swap_req is still high when the FSM returns to IDLE, a second swap starts.
- Outputs x_readdata hold their last value between valid strobes.
- Memory contents are not initialised and are not cleared by reset.

## Timing

- Reset values: bank_sel=0, FSM=IDLE, swap_ack=0, a/b_waitrequest=0, a/b_readdatavalid=0, a/b_readdata=0, in-flight counter=0.
- Read latency: a read accepted at edge N gives readdatavalid=1 after edge N+READ_LATENCY. READ_LATENCY=2 adds one output register stage.
- Back-to-back reads: one read per port per cycle, with no bubbles.
- Write visibility: a write accepted at edge N is visible to a read accepted at edge N+1 or later on the same port.
- Minimum swap: a swap requested with nothing in flight takes 2 cycles (DRAIN, SWAP).
- Maximum swap: a swap requested with reads in flight takes 1+READ_LATENCY+1 cycles.
- Reset asserted mid-operation: all pending readdatavalid strobes are discarded, the FSM returns to IDLE, and bank_sel returns to 0.

## Configuration

- FFT_PP_BITREV_EN defined: the b_bitrev port exists. While b_bitrev=1, the physical port-B address is b_address with bit i moved to bit ADDR_WIDTH-1-i. This applies to reads and writes and is sampled with the command.
- FFT_PP_BITREV_EN undefined: the b_bitrev port is absent and port B always uses natural address order.

## Test plan

- Reset, then write A addr 0x005=0xDEADBEEF (byteenable=0xF), then read A addr 0x005 -> a_readdatavalid 1 cycle later (READ_LATENCY=1) with 0xDEADBEEF. Read B addr 0x005 -> data differs, because B addresses the other bank.
- Byte enables: write 0x11223344 with byteenable=0xF, then 0xAABBCCDD with byteenable=0x5 -> read returns 0x11BB33DD.
- Swap: A writes addr 3=0x1234, then swap_req pulse -> waitrequest high for 2 cycles, swap_ack pulse, bank_sel=1. B then reads addr 3 -> 0x1234.
- Drain: with READ_LATENCY=2, A and B issue reads on the same cycle as swap_req -> both readdatavalid strobes arrive, after which the swap completes. Total waitrequest duration is 4 cycles.
- Bit-reverse (macro on, ADDR_WIDTH=10): A writes addr 0x001=0xCAFE, then swap, then B reads addr 0x200 with b_bitrev=1 -> 0xCAFE.
- Reset during DRAIN with a read in flight -> no readdatavalid, bank_sel=0, waitrequest=0 on the cycle after reset deasserts.

Source files
------------

// File: rtl/fft_acc_pingpong_ram.sv
// Dual-bank ping-pong RAM with two Avalon-MM slave ports and a drain-then-swap bank exchange.
// Define FFT_PP_BITREV_EN to add the b_bitrev port (bit-reversed port-B addressing).
module fft_acc_pingpong_ram #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic                    a_chipselect,
  input  logic                    a_read,
  input  logic                    a_write,
  input  logic [DATA_WIDTH/8-1:0] a_byteenable,
  input  logic [DATA_WIDTH-1:0]   a_writedata,
  output logic [DATA_WIDTH-1:0]   a_readdata,
  output logic                    a_readdatavalid,
  output logic                    a_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic                    b_chipselect,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [DATA_WIDTH/8-1:0] b_byteenable,
  input  logic [DATA_WIDTH-1:0]   b_writedata,
  output logic [DATA_WIDTH-1:0]   b_readdata,
  output logic                    b_readdatavalid,
  output logic                    b_waitrequest,
`ifdef FFT_PP_BITREV_EN
  input  logic                    b_bitrev,
`endif
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    bank_sel
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = $clog2(2 * READ_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StDrain, StSwap} state_e;

  state_e                  state_q;
  logic                    wait_q, swap_ack_q, bank_sel_q;
  logic [CntW-1:0]         inflight_q, inflight_d;
  logic [1:0]              cmd_rd, cmd_wr;
  logic [ADDR_WIDTH:0]     phys [2];
  logic [BeW-1:0]          be [2];
  logic [DATA_WIDTH-1:0]   wdata [2];
  logic [ADDR_WIDTH-1:0]   b_addr_eff;
  logic [DATA_WIDTH-1:0]   mem [2**(ADDR_WIDTH+1)];
  logic [1:0]              rv1_q, rv_out;
  logic [DATA_WIDTH-1:0]   rd1_q [2];
  logic [DATA_WIDTH-1:0]   rd_out [2];

`ifdef FFT_PP_BITREV_EN
  always_comb begin
    b_addr_eff = b_address;
    if (b_bitrev) begin
      for (int i = 0; i < int'(ADDR_WIDTH); i++) b_addr_eff[i] = b_address[ADDR_WIDTH-1-i];
    end
  end
`else
  assign b_addr_eff = b_address;
`endif

  // A simultaneous read+write performs only the write.
  always_comb begin
    cmd_wr[0] = a_chipselect & a_write & ~wait_q;
    cmd_rd[0] = a_chipselect & a_read & ~a_write & ~wait_q;
    cmd_wr[1] = b_chipselect & b_write & ~wait_q;
    cmd_rd[1] = b_chipselect & b_read & ~b_write & ~wait_q;
    phys[0]   = {bank_sel_q, a_address};
    phys[1]   = {~bank_sel_q, b_addr_eff};
    be[0]     = a_byteenable;
    be[1]     = b_byteenable;
    wdata[0]  = a_writedata;
    wdata[1]  = b_writedata;
  end

  // Ports always target opposite banks, so the two writes never collide.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (cmd_wr[p]) begin
        for (int i = 0; i < int'(BeW); i++) begin
          if (be[p][i]) mem[phys[p]][8*i +: 8] <= wdata[p][8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv1_q    <= '0;
      rd1_q[0] <= '0;
      rd1_q[1] <= '0;
    end else begin
      rv1_q <= cmd_rd;
      for (int p = 0; p < 2; p++) begin
        if (cmd_rd[p]) rd1_q[p] <= mem[phys[p]];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            rv2_q;
    logic [DATA_WIDTH-1:0] rd2_q [2];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rv2_q    <= '0;
        rd2_q[0] <= '0;
        rd2_q[1] <= '0;
      end else begin
        rv2_q <= rv1_q;
        for (int p = 0; p < 2; p++) begin
          if (rv1_q[p]) rd2_q[p] <= rd1_q[p];
        end
      end
    end
    assign rv_out    = rv2_q;
    assign rd_out[0] = rd2_q[0];
    assign rd_out[1] = rd2_q[1];
  end else begin : g_lat1
    assign rv_out    = rv1_q;
    assign rd_out[0] = rd1_q[0];
    assign rd_out[1] = rd1_q[1];
  end

  // A read stays counted until the cycle its readdatavalid strobe is visible has ended.
  always_comb begin
    inflight_d = inflight_q + CntW'(cmd_rd[0]) + CntW'(cmd_rd[1])
               - CntW'(rv_out[0]) - CntW'(rv_out[1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= 1'b0;
      swap_ack_q <= 1'b0;
      bank_sel_q <= 1'b0;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      case (state_q)
        StIdle: begin
          if (swap_req) begin
            state_q <= StDrain;
            wait_q  <= 1'b1;
          end
        end
        StDrain: begin
          if (inflight_q == '0) begin
            state_q    <= StSwap;
            swap_ack_q <= 1'b1;
          end
        end
        StSwap: begin
          state_q    <= StIdle;
          swap_ack_q <= 1'b0;
          wait_q     <= 1'b0;
          bank_sel_q <= ~bank_sel_q;
        end
        default: begin
          state_q    <= StIdle;
          swap_ack_q <= 1'b0;
          wait_q     <= 1'b0;
        end
      endcase
    end
  end

  assign a_readdata      = rd_out[0];
  assign b_readdata      = rd_out[1];
  assign a_readdatavalid = rv_out[0];
  assign b_readdatavalid = rv_out[1];
  assign a_waitrequest   = wait_q;
  assign b_waitrequest   = wait_q;
  assign swap_ack        = swap_ack_q;
  assign bank_sel        = bank_sel_q;

endmodule

// File: tb/tb_fft_acc_pingpong_ram.sv
// Bench for fft_acc_pingpong_ram: READ_LATENCY 1 and 2 instances share stimulus, each with
// its own read scoreboard.
module tb_fft_acc_pingpong_ram;

  localparam int AW = 10;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa1[$], qb1[$], qa2[$], qb2[$];

  logic [AW-1:0] a_address, b_address;
  logic          a_chipselect, a_read, a_write, b_chipselect, b_read, b_write, swap_req;
  logic [3:0]    a_byteenable, b_byteenable;
  logic [31:0]   a_writedata, b_writedata;
`ifdef FFT_PP_BITREV_EN
  logic          b_bitrev;
`endif

  logic [31:0] a_readdata1, b_readdata1, a_readdata2, b_readdata2;
  logic a_readdatavalid1, b_readdatavalid1, a_waitrequest1, b_waitrequest1, swap_ack1, bank_sel1;
  logic a_readdatavalid2, b_readdatavalid2, a_waitrequest2, b_waitrequest2, swap_ack2, bank_sel2;

  fft_acc_pingpong_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a_readdata1),
    .a_readdatavalid(a_readdatavalid1), .a_waitrequest(a_waitrequest1),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_readdata(b_readdata1),
    .b_readdatavalid(b_readdatavalid1), .b_waitrequest(b_waitrequest1),
`ifdef FFT_PP_BITREV_EN
    .b_bitrev(b_bitrev),
`endif
    .swap_req(swap_req), .swap_ack(swap_ack1), .bank_sel(bank_sel1)
  );

  fft_acc_pingpong_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a_readdata2),
    .a_readdatavalid(a_readdatavalid2), .a_waitrequest(a_waitrequest2),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_readdata(b_readdata2),
    .b_readdatavalid(b_readdatavalid2), .b_waitrequest(b_waitrequest2),
`ifdef FFT_PP_BITREV_EN
    .b_bitrev(b_bitrev),
`endif
    .swap_req(swap_req), .swap_ack(swap_ack2), .bank_sel(bank_sel2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: every strobe must match the oldest expected read, data and cycle.
  always @(negedge clk) begin : mon_a1
    exp_t e;
    if (!reset && a_readdatavalid1) begin
      checks++;
      if (qa1.size() == 0) begin
        errors++;
        $display("FAIL a_read_l1: unexpected strobe data %h, required no strobe", a_readdata1);
      end else begin
        e = qa1.pop_front();
        if (a_readdata1 !== e.data || cyc !== e.due) begin
          errors++;
          $display("FAIL a_read_l1: data %h cycle %0d, required %h cycle %0d",
                   a_readdata1, cyc, e.data, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b1
    exp_t e;
    if (!reset && b_readdatavalid1) begin
      checks++;
      if (qb1.size() == 0) begin
        errors++;
        $display("FAIL b_read_l1: unexpected strobe data %h, required no strobe", b_readdata1);
      end else begin
        e = qb1.pop_front();
        if (b_readdata1 !== e.data || cyc !== e.due) begin
          errors++;
          $display("FAIL b_read_l1: data %h cycle %0d, required %h cycle %0d",
                   b_readdata1, cyc, e.data, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_a2
    exp_t e;
    if (!reset && a_readdatavalid2) begin
      checks++;
      if (qa2.size() == 0) begin
        errors++;
        $display("FAIL a_read_l2: unexpected strobe data %h, required no strobe", a_readdata2);
      end else begin
        e = qa2.pop_front();
        if (a_readdata2 !== e.data || cyc !== e.due) begin
          errors++;
          $display("FAIL a_read_l2: data %h cycle %0d, required %h cycle %0d",
                   a_readdata2, cyc, e.data, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b2
    exp_t e;
    if (!reset && b_readdatavalid2) begin
      checks++;
      if (qb2.size() == 0) begin
        errors++;
        $display("FAIL b_read_l2: unexpected strobe data %h, required no strobe", b_readdata2);
      end else begin
        e = qb2.pop_front();
        if (b_readdata2 !== e.data || cyc !== e.due) begin
          errors++;
          $display("FAIL b_read_l2: data %h cycle %0d, required %h cycle %0d",
                   b_readdata2, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic idle_bus();
    a_chipselect = 0; a_read = 0; a_write = 0; a_address = '0; a_byteenable = '0;
    a_writedata = '0;
    b_chipselect = 0; b_read = 0; b_write = 0; b_address = '0; b_byteenable = '0;
    b_writedata = '0;
    swap_req = 0;
`ifdef FFT_PP_BITREV_EN
    b_bitrev = 0;
`endif
  endtask

  task automatic step();
    @(negedge clk);
    idle_bus();
  endtask

  task automatic wr_a(input logic [AW-1:0] addr, input logic [31:0] d, input logic [3:0] be);
    a_chipselect = 1; a_write = 1; a_address = addr; a_writedata = d; a_byteenable = be;
  endtask

  task automatic wr_b(input logic [AW-1:0] addr, input logic [31:0] d, input logic [3:0] be);
    b_chipselect = 1; b_write = 1; b_address = addr; b_writedata = d; b_byteenable = be;
  endtask

  task automatic rd_a(input logic [AW-1:0] addr, input logic [31:0] expd);
    a_chipselect = 1; a_read = 1; a_address = addr;
    qa1.push_back('{expd, cyc + 1});
    qa2.push_back('{expd, cyc + 2});
  endtask

  task automatic rd_b(input logic [AW-1:0] addr, input logic [31:0] expd);
    b_chipselect = 1; b_read = 1; b_address = addr;
    qb1.push_back('{expd, cyc + 1});
    qb2.push_back('{expd, cyc + 2});
  endtask

  task automatic settle(input int n);
    repeat (n) step();
    checks++;
    if (qa1.size() + qb1.size() + qa2.size() + qb2.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: %0d reads never returned, required 0",
               qa1.size() + qb1.size() + qa2.size() + qb2.size());
    end
  endtask

  // Call with swap_req (and any same-cycle reads) already driven.
  task automatic measure_swap(output int w1, output int w2, output int k1, output int k2);
    w1 = 0; w2 = 0; k1 = 0; k2 = 0;
    step();
    for (int k = 0; k < 10; k++) begin
      w1 += int'(a_waitrequest1 & b_waitrequest1);
      w2 += int'(a_waitrequest2 & b_waitrequest2);
      k1 += int'(swap_ack1);
      k2 += int'(swap_ack2);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 1;
    repeat (2) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if ({bank_sel1, a_waitrequest1, b_waitrequest1, a_readdatavalid1, b_readdatavalid1,
           swap_ack1, bank_sel2, a_waitrequest2, b_waitrequest2, a_readdatavalid2,
           b_readdatavalid2, swap_ack2} !== 12'b0) begin
        errors++;
        $display("FAIL reset_ctrl: l1 %b l2 %b, required all zero",
                 {bank_sel1, a_waitrequest1, b_waitrequest1, a_readdatavalid1,
                  b_readdatavalid1, swap_ack1},
                 {bank_sel2, a_waitrequest2, b_waitrequest2, a_readdatavalid2,
                  b_readdatavalid2, swap_ack2});
      end
      checks++;
      if ({a_readdata1, b_readdata1, a_readdata2, b_readdata2} !== 128'b0) begin
        errors++;
        $display("FAIL reset_rdata: %h %h %h %h, required zero",
                 a_readdata1, b_readdata1, a_readdata2, b_readdata2);
      end
      reset = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_rw();
    wr_a(10'h005, 32'hDEADBEEF, 4'hF);
    wr_b(10'h005, 32'h0BADF00D, 4'hF);
    step();
    rd_a(10'h005, 32'hDEADBEEF);
    rd_b(10'h005, 32'h0BADF00D);
    step();
    settle(4);
  endtask

  task automatic test_byteenable();
    wr_a(10'h007, 32'h11223344, 4'hF); step();
    wr_a(10'h007, 32'hAABBCCDD, 4'h5); step();
    rd_a(10'h007, 32'h11BB33DD); step();
    // Unselected commands are ignored.
    a_read = 1; a_write = 1; a_address = 10'h007; a_writedata = '0; a_byteenable = 4'hF; step();
    // Read+write: write lands, read produces no strobe.
    wr_a(10'h009, 32'h5A5A0001, 4'hF); a_read = 1; step();
    rd_a(10'h009, 32'h5A5A0001); step();
    rd_a(10'h007, 32'h11BB33DD); step();
    settle(4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wr_a(AW'(16 + i), 32'hA5000000 ^ (32'h01010101 * i), 4'hF);
      wr_b(AW'(16 + i), 32'h3C000000 + 32'(i * 7), 4'hF);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      rd_a(AW'(16 + i), 32'hA5000000 ^ (32'h01010101 * i));
      rd_b(AW'(23 - i), 32'h3C000000 + 32'((7 - i) * 7));
      step();
    end
    settle(4);
  endtask

  task automatic check_swap(input string name, input int w1, input int w2, input int k1,
                            input int k2, input int ew1, input int ew2, input logic ebank);
    checks++;
    if (w1 != ew1 || w2 != ew2) begin
      errors++;
      $display("FAIL %s_wait: l1 %0d l2 %0d cycles, required %0d %0d", name, w1, w2, ew1, ew2);
    end
    checks++;
    if (k1 != 1 || k2 != 1) begin
      errors++;
      $display("FAIL %s_ack: l1 %0d l2 %0d pulses, required 1 1", name, k1, k2);
    end
    checks++;
    if (bank_sel1 !== ebank || bank_sel2 !== ebank) begin
      errors++;
      $display("FAIL %s_bank: l1 %b l2 %b, required %b", name, bank_sel1, bank_sel2, ebank);
    end
  endtask

  task automatic test_swap();
    int w1, w2, k1, k2;
    wr_a(10'h003, 32'h00001234, 4'hF); step();
    swap_req = 1;
    measure_swap(w1, w2, k1, k2);
    check_swap("swap", w1, w2, k1, k2, 2, 2, 1'b1);
    rd_b(10'h003, 32'h00001234);
    rd_a(10'h005, 32'h0BADF00D);
    step();
    settle(4);
  endtask

  task automatic test_drain();
    int w1, w2, k1, k2;
    rd_a(10'h005, 32'h0BADF00D);
    rd_b(10'h005, 32'hDEADBEEF);
    swap_req = 1;
    measure_swap(w1, w2, k1, k2);
    check_swap("drain", w1, w2, k1, k2, 3, 4, 1'b0);
    settle(2);
  endtask

  task automatic test_bitrev();
    int w1, w2, k1, k2;
    wr_a(10'h001, 32'h0000CAFE, 4'hF); step();
    swap_req = 1;
    measure_swap(w1, w2, k1, k2);
    check_swap("bitrev_swap", w1, w2, k1, k2, 2, 2, 1'b1);
    rd_b(10'h001, 32'h0000CAFE); step();
`ifdef FFT_PP_BITREV_EN
    b_bitrev = 1;
    rd_b(10'h200, 32'h0000CAFE); step();
    b_bitrev = 1;
    wr_b(10'h004, 32'h0000BEEF, 4'hF); step();
    rd_b(10'h080, 32'h0000BEEF); step();
`endif
    settle(4);
  endtask

  task automatic test_reset_drain();
    rd_a(10'h005, 32'h0BADF00D);
    swap_req = 1;
    @(posedge clk);
    #1 reset = 1;
    idle_bus();
    qa1.delete(); qa2.delete();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({a_readdatavalid1, a_readdatavalid2, a_waitrequest1, a_waitrequest2, bank_sel1,
         bank_sel2} !== 6'b0) begin
      errors++;
      $display("FAIL reset_drain: rdv/wait/bank %b, required 000000",
               {a_readdatavalid1, a_readdatavalid2, a_waitrequest1, a_waitrequest2, bank_sel1,
                bank_sel2});
    end
    settle(4);
  endtask

  initial begin
    test_reset();
    test_rw();
    test_byteenable();
    test_back_to_back();
    test_swap();
    test_drain();
    test_bitrev();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
